// File: rtl/mips_muldiv.sv
// mips_muldiv: iterative multiply/divide unit with architectural HI/LO.
//
// Serves MULT/MULTU/DIV/DIVU (multi-cycle) and MTHI/MTLO (single edge)
// for the Execute stage, and provides MFHI/MFLO read data combinationally.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   ex_md_valid/op    op request (0 MULT, 1 MULTU, 2 DIV, 3 DIVU,
//                     4 MTHI, 5 MTLO, 6/7 reserved and ignored)
//   ex_md_rega/regb   rs / rt operands, latched at acceptance
//   ex_md_readhl      MFHI/MFLO request (only affects stall)
//   ex_md_selhi       selects HI (1) or LO (0) onto md_ex_result
//   flush             aborts an in-flight op or drops an idle request
//   md_ex_ready/busy  idle / op in flight (ready = ~busy)
//   md_ex_stall       pipeline must hold this cycle
//   md_ex_result      committed HI or LO
//   md_ex_divzero     one-cycle pulse after a divide-by-zero commits
//   hi, lo            architectural HI/LO
//   dbg_state         current FSM state (0 IDLE, 1 RUN, 2 FIX)
//
// Handshake: a request is taken on a rising edge where ex_md_valid=1 and
// md_ex_ready=1 (and flush=0); while busy the requester holds the request
// and md_ex_stall tells the pipeline to wait.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ex_md_valid,
    input  logic [2:0]       ex_md_op,
    input  logic [WIDTH-1:0] ex_md_rega,
    input  logic [WIDTH-1:0] ex_md_regb,
    input  logic             ex_md_readhl,
    input  logic             ex_md_selhi,
    input  logic             flush,
    output logic             md_ex_ready,
    output logic             md_ex_busy,
    output logic             md_ex_stall,
    output logic [WIDTH-1:0] md_ex_result,
    output logic             md_ex_divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             is_signed;
    logic [WIDTH-1:0] rs_q;
    logic [WIDTH-1:0] rt_q;
    // acc_hi: partial product high half (mul) or partial remainder (div).
    // acc_lo: multiplier bits shifting out (mul) or dividend bits shifting
    //         out while quotient bits shift in (div).
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    // Magnitude added each step (multiplicand) or subtracted (divisor).
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             divzero_q;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic sgn);
        // -MIN wraps to MIN, which is the correct unsigned magnitude.
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    // Request decode for the idle cycle.
    logic             req_signed;
    logic             req_div;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        req_signed = (ex_md_op == 3'd0) || (ex_md_op == 3'd2);
        req_div    = (ex_md_op == 3'd2) || (ex_md_op == 3'd3);
        mag_a      = mag(ex_md_rega, req_signed);
        mag_b      = mag(ex_md_regb, req_signed);
    end

    // One radix-2 iteration.
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        add_sum = '0;
        shifted = '0;
        trial   = '0;
        step_hi = acc_hi;
        step_lo = acc_lo;
        if (is_div) begin
            // Restoring step: keep the subtraction only if it stays >= 0.
            shifted = {acc_hi, acc_lo[WIDTH-1]};
            trial   = shifted - {1'b0, opnd};
            if (!trial[WIDTH]) begin
                step_hi = trial[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = shifted[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift-add step: conditional add, then shift the pair right.
            add_sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd})
                                : {1'b0, acc_hi};
            step_hi = add_sum[WIDTH:1];
            step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override applied in FIX.
    logic                 neg_res;
    logic                 dz_det;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     fix_hi;
    logic [WIDTH-1:0]     fix_lo;

    always_comb begin
        neg_res  = is_signed && (rs_q[WIDTH-1] ^ rt_q[WIDTH-1]);
        dz_det   = is_div && (rt_q == '0);
        prod_fix = {acc_hi, acc_lo};
        fix_hi   = acc_hi;
        fix_lo   = acc_lo;
        if (is_div) begin
            if (dz_det) begin
                fix_hi = rs_q;
                fix_lo = '1;
            end else begin
                fix_lo = neg_res ? (~acc_lo + 1'b1) : acc_lo;
                fix_hi = (is_signed && rs_q[WIDTH-1]) ? (~acc_hi + 1'b1) : acc_hi;
            end
        end else begin
            if (neg_res) begin
                prod_fix = ~{acc_hi, acc_lo} + 1'b1;
            end
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            rs_q      <= '0;
            rt_q      <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
        end else begin
            divzero_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ex_md_valid && !flush) begin
                        case (ex_md_op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                state     <= S_RUN;
                                cnt       <= '0;
                                is_div    <= req_div;
                                is_signed <= req_signed;
                                rs_q      <= ex_md_rega;
                                rt_q      <= ex_md_regb;
                                acc_hi    <= '0;
                                acc_lo    <= req_div ? mag_a : mag_b;
                                opnd      <= req_div ? mag_b : mag_a;
                            end
                            3'd4:    hi_q <= ex_md_rega;
                            3'd5:    lo_q <= ex_md_rega;
                            default: ;
                        endcase
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!flush) begin
                        hi_q      <= fix_hi;
                        lo_q      <= fix_lo;
                        divzero_q <= dz_det;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign md_ex_busy    = (state != S_IDLE);
    assign md_ex_ready   = ~md_ex_busy;
    assign md_ex_stall   = md_ex_busy &&
                           ((ex_md_valid && (ex_md_op <= 3'd5)) || ex_md_readhl);
    assign md_ex_result  = ex_md_selhi ? hi_q : lo_q;
    assign md_ex_divzero = divzero_q;
    assign hi            = hi_q;
    assign lo            = lo_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_mips_muldiv.sv
module tb_mips_muldiv;

    logic        clock;
    logic        reset;

    // 32-bit instance
    logic        v32, rd32, sh32, fl32;
    logic [2:0]  op32;
    logic [31:0] a32, b32;
    logic        rdy32, busy32, stall32, dz32;
    logic [31:0] res32, hi32, lo32;
    logic [1:0]  st32;

    // 8-bit instance
    logic        v8, rd8, sh8, fl8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8;
    logic        rdy8, busy8, stall8, dz8;
    logic [7:0]  res8, hi8, lo8;
    logic [1:0]  st8;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [15:0] exp8_q[$];

    mips_muldiv #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset),
        .ex_md_valid(v32), .ex_md_op(op32), .ex_md_rega(a32), .ex_md_regb(b32),
        .ex_md_readhl(rd32), .ex_md_selhi(sh32), .flush(fl32),
        .md_ex_ready(rdy32), .md_ex_busy(busy32), .md_ex_stall(stall32),
        .md_ex_result(res32), .md_ex_divzero(dz32), .hi(hi32), .lo(lo32),
        .dbg_state(st32)
    );

    mips_muldiv #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset),
        .ex_md_valid(v8), .ex_md_op(op8), .ex_md_rega(a8), .ex_md_regb(b8),
        .ex_md_readhl(rd8), .ex_md_selhi(sh8), .flush(fl8),
        .md_ex_ready(rdy8), .md_ex_busy(busy8), .md_ex_stall(stall8),
        .md_ex_result(res8), .md_ex_divzero(dz8), .hi(hi8), .lo(lo8),
        .dbg_state(st8)
    );

    // ---------------- clock ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model for the 32-bit unit: {hi, lo} from native arithmetic.
    function automatic logic [63:0] model32(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (op)
            3'd0: p = sa * sb;
            3'd1: p = {32'd0, a} * {32'd0, b};
            3'd2, 3'd3: begin
                if (b == 32'd0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else begin
                    if (op == 3'd3) begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: p = '0;
        endcase
        return p;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_idle32();
        v32 = 1'b0; op32 = 3'd0; a32 = '0; b32 = '0;
        rd32 = 1'b0; sh32 = 1'b0; fl32 = 1'b0;
    endtask

    // Issue a mul/div on the 32-bit unit and check length, result, divzero.
    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        logic [63:0] e;
        @(negedge clock);
        v32 = 1'b1; op32 = op; a32 = a; b32 = b;
        exp_q.push_back(model32(op, a, b));
        @(posedge clock);
        #1;
        v32 = 1'b0;
        a32 = $urandom;          // operands must already be latched
        b32 = $urandom;
        n = 0;
        @(negedge clock);
        while (busy32 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk($sformatf("op%0d_busy_len", op), 64'(n), 64'd33);
        e = exp_q.pop_front();
        chk($sformatf("op%0d_hi a=%0h b=%0h", op, a, b), {32'd0, hi32}, {32'd0, e[63:32]});
        chk($sformatf("op%0d_lo a=%0h b=%0h", op, a, b), {32'd0, lo32}, {32'd0, e[31:0]});
        chk($sformatf("op%0d_divzero", op), {63'd0, dz32},
            {63'd0, (op >= 3'd2) && (b == 32'd0)});
        @(negedge clock);
        chk($sformatf("op%0d_divzero_clear", op), {63'd0, dz32}, 64'd0);
        chk($sformatf("op%0d_ready", op), {63'd0, rdy32}, 64'd1);
    endtask

    task automatic move32(input logic [2:0] op, input logic [31:0] a);
        @(negedge clock);
        v32 = 1'b1; op32 = op; a32 = a;
        #1;
        chk("move_no_stall", {63'd0, stall32}, 64'd0);
        @(posedge clock);
        #1;
        v32 = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] e;
        logic [15:0] e8;
        logic        flag;
        int          n;

        drive_idle32();
        v8 = 1'b0; op8 = 3'd0; a8 = '0; b8 = '0; rd8 = 1'b0; sh8 = 1'b0; fl8 = 1'b0;

        // Reset
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_hi", {32'd0, hi32}, 64'd0);
        chk("rst_lo", {32'd0, lo32}, 64'd0);
        chk("rst_ready", {63'd0, rdy32}, 64'd1);
        chk("rst_busy", {63'd0, busy32}, 64'd0);
        chk("rst_stall", {63'd0, stall32}, 64'd0);
        chk("rst_divzero", {63'd0, dz32}, 64'd0);
        chk("rst8_hilo", {48'd0, hi8, lo8}, 64'd0);

        // Directed mul/div vectors
        run32(3'd1, 32'hFFFF_FFFF, 32'h2);
        chk("multu_hi_lit", {32'd0, hi32}, 64'h1);
        chk("multu_lo_lit", {32'd0, lo32}, 64'hFFFF_FFFE);
        run32(3'd0, -32'sd3, 32'd7);
        chk("mult_lo_lit", {32'd0, lo32}, 64'hFFFF_FFEB);
        run32(3'd2, -32'sd7, 32'd2);
        chk("div_lo_lit", {32'd0, lo32}, 64'hFFFF_FFFD);
        chk("div_hi_lit", {32'd0, hi32}, 64'hFFFF_FFFF);
        run32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_min_lo_lit", {32'd0, lo32}, 64'h8000_0000);
        chk("div_min_hi_lit", {32'd0, hi32}, 64'h0);
        run32(3'd3, 32'd100, 32'd7);
        chk("divu_lit", {hi32, lo32}, {32'd2, 32'd14});
        run32(3'd3, 32'h1234, 32'd0);
        chk("divu_zero_lit", {hi32, lo32}, {32'h1234, 32'hFFFF_FFFF});
        run32(3'd2, -32'sd9, 32'd0);
        run32(3'd0, 32'h8000_0000, 32'h8000_0000);
        run32(3'd2, 32'd17, -32'sd5);

        for (int i = 0; i < 4; i++) begin
            run32(3'(i), $urandom, $urandom_range(1, 32'hFFFF));
        end

        // Hazard: MFHI issued 5 cycles into a MULT
        @(negedge clock);
        v32 = 1'b1; op32 = 3'd0; a32 = 32'd5; b32 = -32'sd9;
        exp_q.push_back(model32(3'd0, 32'd5, -32'sd9));
        @(posedge clock);
        #1;
        v32 = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        rd32 = 1'b1; sh32 = 1'b1;
        flag = 1'b1;
        n = 0;
        @(negedge clock);
        while (busy32 && n < 100) begin
            if (stall32 !== 1'b1) flag = 1'b0;
            n++;
            @(negedge clock);
        end
        chk("hazard_stall_held", {63'd0, flag}, 64'd1);
        chk("hazard_stall_cycles", 64'(n), 64'd28);
        chk("hazard_stall_release", {63'd0, stall32}, 64'd0);
        e = exp_q.pop_front();
        chk("hazard_mfhi", {32'd0, res32}, {32'd0, e[63:32]});
        sh32 = 1'b0;
        #1;
        chk("hazard_mflo", {32'd0, res32}, {32'd0, e[31:0]});
        rd32 = 1'b0;

        // MTLO while idle
        move32(3'd5, 32'hA5);
        chk("mtlo_lo", {32'd0, lo32}, 64'hA5);
        chk("mtlo_busy", {63'd0, busy32}, 64'd0);

        // Flush of an in-flight divide
        move32(3'd4, 32'h55);
        chk("mthi_hi", {32'd0, hi32}, 64'h55);
        @(negedge clock);
        v32 = 1'b1; op32 = 3'd2; a32 = 32'd100; b32 = 32'd0;
        @(posedge clock);
        #1;
        v32 = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        fl32 = 1'b1;
        @(posedge clock);
        #1;
        fl32 = 1'b0;
        chk("flush_idle", {62'd0, st32}, 64'd0);
        chk("flush_busy", {63'd0, busy32}, 64'd0);
        flag = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (dz32 !== 1'b0) flag = 1'b1;
        end
        chk("flush_no_divzero", {63'd0, flag}, 64'd0);
        chk("flush_hi_kept", {32'd0, hi32}, 64'h55);
        chk("flush_lo_kept", {32'd0, lo32}, 64'hA5);

        // Flush together with an idle request drops it
        @(negedge clock);
        v32 = 1'b1; op32 = 3'd4; a32 = 32'h77; fl32 = 1'b1;
        @(posedge clock);
        #1;
        v32 = 1'b0; fl32 = 1'b0;
        chk("flush_drop_mthi", {32'd0, hi32}, 64'h55);
        @(negedge clock);
        v32 = 1'b1; op32 = 3'd1; a32 = 32'd3; b32 = 32'd3; fl32 = 1'b1;
        @(posedge clock);
        #1;
        v32 = 1'b0; fl32 = 1'b0;
        chk("flush_drop_mul", {63'd0, busy32}, 64'd0);

        // Flush with nothing in flight
        @(negedge clock);
        fl32 = 1'b1;
        @(posedge clock);
        #1;
        fl32 = 1'b0;
        chk("flush_noop", {hi32, lo32}, {32'h55, 32'hA5});

        // Reserved op in idle is ignored
        @(negedge clock);
        v32 = 1'b1; op32 = 3'd6; a32 = 32'hDEAD; b32 = 32'h1;
        @(posedge clock);
        #1;
        v32 = 1'b0;
        chk("rsvd_idle_busy", {63'd0, busy32}, 64'd0);
        chk("rsvd_idle_hilo", {hi32, lo32}, {32'h55, 32'hA5});

        // Reserved op never stalls; a real op during busy does
        @(negedge clock);
        v32 = 1'b1; op32 = 3'd1; a32 = 32'd1000; b32 = 32'd1000;
        exp_q.push_back(model32(3'd1, 32'd1000, 32'd1000));
        @(posedge clock);
        #1;
        op32 = 3'd7;
        #1;
        chk("rsvd_busy_no_stall", {63'd0, stall32}, 64'd0);
        op32 = 3'd4;
        #1;
        chk("mthi_busy_stall", {63'd0, stall32}, 64'd1);
        v32 = 1'b0;
        n = 0;
        @(negedge clock);
        while (busy32 && n < 100) begin
            n++;
            @(negedge clock);
        end
        e = exp_q.pop_front();
        chk("held_req_not_taken_hilo", {hi32, lo32}, e);

        // WIDTH=8 unit
        @(negedge clock);
        v8 = 1'b1; op8 = 3'd1; a8 = 8'hFF; b8 = 8'hFF;
        exp8_q.push_back(16'hFE01);
        @(posedge clock);
        #1;
        v8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        n = 0;
        @(negedge clock);
        while (busy8 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk("w8_busy_len", 64'(n), 64'd9);
        e8 = exp8_q.pop_front();
        chk("w8_multu", {48'd0, hi8, lo8}, {48'd0, e8});
        @(negedge clock);
        v8 = 1'b1; op8 = 3'd2; a8 = 8'hF9; b8 = 8'h02;   // -7 / 2
        exp8_q.push_back({8'hFF, 8'hFD});
        @(posedge clock);
        #1;
        v8 = 1'b0;
        n = 0;
        @(negedge clock);
        while (busy8 && n < 100) begin
            n++;
            @(negedge clock);
        end
        e8 = exp8_q.pop_front();
        chk("w8_div", {48'd0, hi8, lo8}, {48'd0, e8});

        // Reset in the middle of an operation
        @(negedge clock);
        v32 = 1'b1; op32 = 3'd1; a32 = 32'h1234_5678; b32 = 32'h9;
        @(posedge clock);
        #1;
        v32 = 1'b0;
        repeat (4) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_busy", {63'd0, busy32}, 64'd0);
        chk("midrst_ready", {63'd0, rdy32}, 64'd1);
        chk("midrst_hilo", {hi32, lo32}, 64'd0);
        chk("midrst_w8_hilo", {48'd0, hi8, lo8}, 64'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("midrst_stays_idle", {62'd0, st32}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.
- Sits beside the Execute stage and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- Raises a stall toward Fetch/Execute whenever an instruction needs the unit while an operation is still in flight.
- Generalises the fixed 32-bit datapath to any WIDTH, and adds multi-cycle scheduling, a flush abort and divide-by-zero reporting.

Parameters:
WIDTH, 32, operand/HI/LO width; legal range 4..64. Iteration counter width is derived internally as clog2(WIDTH+1).

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
ex_md_valid  input  1  op request this cycle
ex_md_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved
ex_md_rega  input  WIDTH  rs operand (multiplicand / dividend / MTxx data)
ex_md_regb  input  WIDTH  rt operand (multiplier / divisor)
ex_md_readhl  input  1  MFHI/MFLO request this cycle
ex_md_selhi  input  1  1 selects HI, 0 selects LO for result
flush  input  1  abort the in-flight op (branch/exception squash)
md_ex_ready  output  1  unit idle; a request is accepted this cycle
md_ex_busy  output  1  operation in flight
md_ex_stall  output  1  pipeline must hold
md_ex_result  output  WIDTH  combinational HI or LO per ex_md_selhi
md_ex_divzero  output  1  one-cycle pulse when a divide by zero completes
hi  output  WIDTH  architectural HI
lo  output  WIDTH  architectural LO

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, hi=0, lo=0, counter=0, md_ex_busy=0, md_ex_divzero=0, md_ex_ready=1.
- States and transitions:
  - IDLE: accept a request when ex_md_valid=1. Ops 0-3 go to RUN; ops 4-5 stay in IDLE; ops 6-7 are ignored with no state change.
  - RUN: one radix-2 iteration per clock for WIDTH clocks, then FIX.
  - FIX: sign correction, then HI/LO written on the next edge; return to IDLE.
- Timing:
  - Mul/div accepted at edge E0 updates HI/LO at edge E0+WIDTH+1.
  - md_ex_busy is 1 for exactly WIDTH+1 cycles.
  - md_ex_ready = ~md_ex_busy.
- MTHI/MTLO accepted in IDLE write hi/lo at the accepting edge with no busy cycle.
- Multiply:
  - Shift-add on magnitudes, producing a 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
  - Signed ops negate the product when the operand signs differ.
- Divide:
  - Restoring division on magnitudes; lo = quotient, hi = remainder.
  - Signed ops: quotient negated when signs differ; remainder takes the sign of the dividend.
  - MIN / -1: lo = MIN, hi = 0 (wraps, no trap).
- Divide by zero (signed or unsigned): lo = all ones, hi = rs unchanged. md_ex_divzero pulses high in the cycle after the write edge.
- Operands are latched at acceptance; later changes on ex_md_rega/ex_md_regb have no effect.
- md_ex_stall = md_ex_busy & ((ex_md_valid & ex_md_op<=5) | ex_md_readhl). Requests during busy are not accepted; the requester holds them until ready.
- md_ex_result always reflects the committed hi/lo, never partial state.
- flush:
  - Asserted in RUN/FIX: return to IDLE at the next edge; hi/lo keep their pre-op values; no divzero pulse.
  - flush in the same cycle as ex_md_valid in IDLE: the request is dropped.
  - flush with no op in flight: no effect.
- Reset mid-operation: immediate return to the reset values above.
- Reserved ops 6/7 never assert stall.

Test Plan:
- Reset: reset low, then high -> hi=0, lo=0, md_ex_ready=1, md_ex_busy=0, md_ex_stall=0.
- MULTU: rs=0xFFFFFFFF, rt=0x2 -> busy for 33 cycles; hi=0x00000001, lo=0xFFFFFFFE at E0+33. MULT: rs=-3, rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV: rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV: rs=0x80000000, rt=-1 -> lo=0x80000000, hi=0. DIVU: rs=100, rt=7 -> lo=14, hi=2.
- Divide by zero: DIVU rs=0x1234, rt=0 -> lo=0xFFFFFFFF, hi=0x1234; md_ex_divzero high for exactly 1 cycle.
- Hazard: MFHI (ex_md_readhl=1) issued 5 cycles after MULT accept -> md_ex_stall=1 until busy falls; md_ex_result then equals the new hi. MTLO 0xA5 while idle -> lo=0xA5 next edge, no stall.
- flush: after MTHI 0x55, start DIV and assert flush at cycle 10 -> IDLE next edge, hi=0x55 retained, no divzero pulse. Repeat with WIDTH=8: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01 after 9 busy cycles.
